// File: rtl/encoder_8to3_pkg.sv
// rtl/encoder_8to3_pkg.sv - shared widths, output record and reference priority encode
package encoder_8to3_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;

    typedef struct packed {
        logic [ENC_OUT_W-1:0] code;
        logic                 valid;
        logic                 multi_hot;
    } enc_out_t;

    // Highest set bit wins; code is 0 with valid low when nothing is requested.
    function automatic enc_out_t f_prio_enc8(input logic [ENC_IN_W-1:0] vec);
        enc_out_t res;
        res.code = '0;
        casez (vec)
            8'b1???????: res.code = 3'd7;
            8'b01??????: res.code = 3'd6;
            8'b001?????: res.code = 3'd5;
            8'b0001????: res.code = 3'd4;
            8'b00001???: res.code = 3'd3;
            8'b000001??: res.code = 3'd2;
            8'b0000001?: res.code = 3'd1;
            default:     res.code = 3'd0;
        endcase
        res.valid     = |vec;
        res.multi_hot = |(vec & (vec - 8'd1));
        return res;
    endfunction

endpackage

// File: rtl/encoder_8to3_comb.sv
// rtl/encoder_8to3_comb.sv - combinational priority encoder with zero and multi-hot detect
module encoder_8to3_comb
    import encoder_8to3_pkg::*;
(
    input  logic [ENC_IN_W-1:0] vec_i,
    output enc_out_t            enc_o
);

    logic [ENC_OUT_W-1:0] code;

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        code = '0;
        for (int k = 0; k < ENC_IN_W; k++) begin
            if (vec_i[k]) begin
                code = ENC_OUT_W'(k);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign enc_o.code      = code;
    assign enc_o.valid     = |vec_i;
    assign enc_o.multi_hot = |(vec_i & (vec_i - ENC_IN_W'(1)));

endmodule

// File: rtl/encoder_8to3.sv
// rtl/encoder_8to3.sv - registered 8-to-3 priority encoder with valid and multi-hot flags
module encoder_8to3
    import encoder_8to3_pkg::*;
#(
    parameter int IN_W = ENC_IN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] i,
    output logic            a,
    output logic            b,
    output logic            c,
    output logic            valid,
    output logic            multi_hot
);

    localparam int OUT_W = $clog2(IN_W);

    if (IN_W != ENC_IN_W) begin : g_bad_width
        $error("encoder_8to3: IN_W must be 8");
    end

    enc_out_t out_d;
    enc_out_t out_q;

    encoder_8to3_comb u_comb (
        .vec_i (i[ENC_IN_W-1:0]),
        .enc_o (out_d)
    );

    // Async clear beats a coincident edge, so the sample at that edge is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign a         = out_q.code[OUT_W-1];
    assign b         = out_q.code[1];
    assign c         = out_q.code[0];
    assign valid     = out_q.valid;
    assign multi_hot = out_q.multi_hot;

endmodule

// File: tb/tb_encoder_8to3.sv
// tb/tb_encoder_8to3.sv - directed self-checking bench for encoder_8to3
module tb_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] i;
    logic       a;
    logic       b;
    logic       c;
    logic       valid;
    logic       multi_hot;

    int n_assert = 0;
    int n_fail   = 0;

    encoder_8to3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (i),
        .a         (a),
        .b         (b),
        .c         (c),
        .valid     (valid),
        .multi_hot (multi_hot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] exp_code,
                         input logic exp_valid, input logic exp_mh);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {a, b, c, valid, multi_hot};
        exp = {exp_code, exp_valid, exp_mh};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed code=%b valid=%b multi_hot=%b, expected code=%b valid=%b multi_hot=%b",
                   tag, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic step_and_check(input string tag, input logic [7:0] vec,
                                  input logic [2:0] exp_code, input logic exp_valid,
                                  input logic exp_mh);
        i = vec;
        @(posedge clk);
        @(negedge clk);
        check(tag, exp_code, exp_valid, exp_mh);
    endtask

    initial begin
        rst_n = 1'b0;
        i     = 8'hFF;

        // Reset held with all requests set: outputs stay cleared across edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_hold", 3'b000, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_release", 3'b111, 1'b1, 1'b1);

        // One-hot walk with an asynchronous reset pulse between edges after m=3.
        for (int m = 0; m < 8; m++) begin
            logic [7:0] onehot;
            onehot = 8'd1;
            onehot = onehot << m;
            step_and_check($sformatf("walk_%0d", m), onehot, 3'(m), 1'b1, 1'b0);
            if (m == 3) begin
                #2 rst_n = 1'b0;
                #1 check("async_clear", 3'b000, 1'b0, 1'b0);
                @(posedge clk);
                #1 check("clear_over_edge", 3'b000, 1'b0, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        step_and_check("zero", 8'h00, 3'b000, 1'b0, 1'b0);
        step_and_check("multi_A0", 8'hA0, 3'b111, 1'b1, 1'b1);
        step_and_check("multi_06", 8'h06, 3'b010, 1'b1, 1'b1);
        step_and_check("multi_FF", 8'hFF, 3'b111, 1'b1, 1'b1);
        step_and_check("zero_after_multi", 8'h00, 3'b000, 1'b0, 1'b0);

        // Latency: a mid-cycle input change must not reach the outputs before the edge.
        step_and_check("latency_04", 8'h04, 3'b010, 1'b1, 1'b0);
        #2 i = 8'h40;
        #1 check("latency_hold", 3'b010, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("latency_40", 3'b110, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
